// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing stage.
// Opcodes, FSM states and ALU control reset values.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LDI   = 4'd1,
        OP_LDB   = 4'd2,
        OP_ALUL  = 4'd3,
        OP_ALUA  = 4'd4,
        OP_ALUAC = 4'd5,
        OP_STB   = 4'd6
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam logic [3:0] ALU_SEL_RST = 4'h0;
    localparam logic       ALU_M_RST   = 1'b1;
    localparam logic       ALU_CN_RST  = 1'b1;

endpackage

// File: rtl/alu_exec_ctrl.sv
// Sequencing stage in front of the 4-bit ALU: accepts instructions, owns the
// accumulator/B registers, drives ALU controls and captures F after settling.
module alu_exec_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [3:0] instr_imm,
    output logic [3:0] alu_sel,
    output logic       alu_m,
    output logic       alu_cn,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_f,
    input  logic       alu_abflag,
    output logic [3:0] acc,
    output logic       flag_zero,
    output logic       flag_eq,
    output logic       busy,
    output logic       done
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("alu_exec_ctrl: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] breg_q, breg_d;
    logic [3:0] sel_q, sel_d;
    logic       m_q, m_d;
    logic       cn_q, cn_d;
    logic       fz_q, fz_d;
    logic       feq_q, feq_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       xfer_s;

    // Ready is gated by rst so an instruction presented during reset is never taken.
    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign xfer_s      = instr_valid && instr_ready;

    assign alu_a     = acc_q;
    assign alu_b     = breg_q;
    assign alu_sel   = sel_q;
    assign alu_m     = m_q;
    assign alu_cn    = cn_q;
    assign acc       = acc_q;
    assign flag_zero = fz_q;
    assign flag_eq   = feq_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state logic for the FSM, settle counter and architectural registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        breg_d  = breg_q;
        sel_d   = sel_q;
        m_d     = m_q;
        cn_d    = cn_q;
        fz_d    = fz_q;
        feq_d   = feq_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    case (instr_op)
                        OP_LDI: begin
                            acc_d  = instr_imm;
                            done_d = 1'b1;
                        end
                        OP_LDB: begin
                            breg_d = instr_imm;
                            done_d = 1'b1;
                        end
                        OP_STB: begin
                            breg_d = acc_q;
                            done_d = 1'b1;
                        end
                        OP_ALUL: begin
                            sel_d   = instr_imm;
                            m_d     = 1'b1;
                            cn_d    = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = ST_EXEC;
                        end
                        OP_ALUA: begin
                            sel_d   = instr_imm;
                            m_d     = 1'b0;
                            cn_d    = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = ST_EXEC;
                        end
                        OP_ALUAC: begin
                            sel_d   = instr_imm;
                            m_d     = 1'b0;
                            cn_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = ST_EXEC;
                        end
                        // NOP and the unassigned opcodes retire without side effects.
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_WB: begin
                acc_d   = alu_f;
                fz_d    = (alu_f == 4'd0);
                feq_d   = alu_abflag;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            acc_q   <= 4'd0;
            breg_q  <= 4'd0;
            sel_q   <= ALU_SEL_RST;
            m_q     <= ALU_M_RST;
            cn_q    <= ALU_CN_RST;
            fz_q    <= 1'b0;
            feq_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            breg_q  <= breg_d;
            sel_q   <= sel_d;
            m_q     <= m_d;
            cn_q    <= cn_d;
            fz_q    <= fz_d;
            feq_q   <= feq_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

endmodule
